// File: rtl/uart_rx_hex_pkg.sv
// Shared types and constants for the uart_rx_hex receiver: FSM state encoding
// and the ASCII code points bounding the legal hex-digit characters.
package uart_rx_hex_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } rx_state_e;

  localparam logic [7:0] ASCII_DIGIT_LO = 8'h30;  // '0'
  localparam logic [7:0] ASCII_DIGIT_HI = 8'h39;  // '9'
  localparam logic [7:0] ASCII_UPPER_LO = 8'h41;  // 'A'
  localparam logic [7:0] ASCII_UPPER_HI = 8'h46;  // 'F'
  localparam logic [7:0] ASCII_LOWER_LO = 8'h61;  // 'a'
  localparam logic [7:0] ASCII_LOWER_HI = 8'h66;  // 'f'

endpackage

// File: rtl/uart_rx_hex_decoder.sv
// Combinational ASCII-to-hex-digit decoder: maps '0'-'9', 'A'-'F', 'a'-'f'
// to a 4-bit nibble with a valid flag; anything else decodes to 0 / invalid.
module hex_digit_decoder
  import uart_rx_hex_pkg::*;
(
  input  logic [7:0] ascii_in,
  output logic [3:0] nibble_out,
  output logic       valid_out
);

  logic is_digit;
  logic is_upper;
  logic is_lower;

  assign is_digit = (ascii_in >= ASCII_DIGIT_LO) && (ascii_in <= ASCII_DIGIT_HI);
  assign is_upper = (ascii_in >= ASCII_UPPER_LO) && (ascii_in <= ASCII_UPPER_HI);
  assign is_lower = (ascii_in >= ASCII_LOWER_LO) && (ascii_in <= ASCII_LOWER_HI);

  always_comb begin
    // NOTE: outputs get defaults before any branch so no path leaves them
    // unassigned, which would otherwise infer a latch.
    nibble_out = 4'd0;
    valid_out  = 1'b0;
    if (is_digit) begin
      nibble_out = ascii_in[3:0];
      valid_out  = 1'b1;
    end else if (is_upper || is_lower) begin
      // Letters a-f / A-F have low nibble 1..6; adding 9 yields 10..15.
      nibble_out = ascii_in[3:0] + 4'd9;
      valid_out  = 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_hex.sv
// UART 8N1 receiver with ASCII hex-digit decode and a one-cycle ready strobe.
// Optional macro UART_RX_HEX_FRAME_ERR_EN adds a frame_err pulse output.
module uart_rx_hex
  import uart_rx_hex_pkg::*;
#(
  parameter int CLOCK_RATE = 100_000_000,
  parameter int BAUD_RATE  = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic [3:0] hex_out,
  output logic       hex_valid,
`ifdef UART_RX_HEX_FRAME_ERR_EN
  output logic       frame_err,
`endif
  output logic       ready_out
);

  localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT + 1);

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

  logic [1:0]       sync_q;
  logic             rx_s;
  rx_state_e        state_q,   state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q,   shift_d;
  logic [7:0]       data_q,    data_d;
  logic [3:0]       hex_q,     hex_d;
  logic             valid_q,   valid_d;
  logic             ready_q,   ready_d;
`ifdef UART_RX_HEX_FRAME_ERR_EN
  logic             frame_err_q, frame_err_d;
`endif

  logic [3:0]       dec_nibble;
  logic             dec_valid;

  // Two-flop synchroniser; resets to the idle-high line level so reset
  // release never looks like a start bit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values, modelling real registers.
      sync_q <= {sync_q[0], rx};
    end
  end

  assign rx_s = sync_q[1];

  // The assembled byte is stable throughout STOP, so decoding it here lets
  // the commit register the nibble alongside the byte.
  hex_digit_decoder u_decoder (
    .ascii_in   (shift_q),
    .nibble_out (dec_nibble),
    .valid_out  (dec_valid)
  );

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    hex_d     = hex_q;
    valid_d   = valid_q;
    ready_d   = 1'b0;
`ifdef UART_RX_HEX_FRAME_ERR_EN
    frame_err_d = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d   = START;
          clk_cnt_d = '0;
          bit_idx_d = '0;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          // Returning to IDLE at mid-stop leaves room to catch a start bit
          // that follows the stop bit with no idle gap.
          clk_cnt_d = '0;
          state_d   = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            hex_d   = dec_nibble;
            valid_d = dec_valid;
            ready_d = 1'b1;
          end else begin
`ifdef UART_RX_HEX_FRAME_ERR_EN
            frame_err_d = 1'b1;
`endif
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      hex_q     <= '0;
      valid_q   <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      hex_q     <= hex_d;
      valid_q   <= valid_d;
      ready_q   <= ready_d;
    end
  end

`ifdef UART_RX_HEX_FRAME_ERR_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_err_q <= 1'b0;
    end else begin
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;
`endif

  assign data_out  = data_q;
  assign hex_out   = hex_q;
  assign hex_valid = valid_q;
  assign ready_out = ready_q;

endmodule

// File: tb/tb_uart_rx_hex.sv
// Scoreboard bench for uart_rx_hex at 10 clocks per bit: directed frames push
// hand-computed expectations; a monitor pops and compares on each ready_out.
`timescale 1ns/1ps
module tb_uart_rx_hex;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       rx;
  logic [7:0] data_out;
  logic [3:0] hex_out;
  logic       hex_valid;
  logic       ready_out;
`ifdef UART_RX_HEX_FRAME_ERR_EN
  logic       frame_err;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic [3:0] hex;
    logic       valid;
  } exp_t;

  exp_t exp_q[$];
  exp_t cur;
  int   total     = 0;
  int   bad       = 0;
  int   strobes   = 0;
  int   ferr_seen = 0;

  always #5 clk = ~clk;

  uart_rx_hex #(
    .CLOCK_RATE (1_000_000),
    .BAUD_RATE  (100_000)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .rx        (rx),
    .data_out  (data_out),
    .hex_out   (hex_out),
    .hex_valid (hex_valid),
`ifdef UART_RX_HEX_FRAME_ERR_EN
    .frame_err (frame_err),
`endif
    .ready_out (ready_out)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && ready_out) begin
      strobes++;
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'd1, 32'd0);
      end else begin
        cur = exp_q.pop_front();
        check("data_out",  {24'd0, data_out}, {24'd0, cur.data});
        check("hex_out",   {28'd0, hex_out},  {28'd0, cur.hex});
        check("hex_valid", {31'd0, hex_valid}, {31'd0, cur.valid});
      end
    end
`ifdef UART_RX_HEX_FRAME_ERR_EN
    if (!reset && frame_err) begin
      ferr_seen++;
      check("ferr_with_ready", {31'd0, ready_out}, 32'd0);
    end
`endif
  end

  task automatic drive_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic expect_strobe, input logic [3:0] h, input logic v);
    exp_t e;
    if (expect_strobe) begin
      e.data  = b;
      e.hex   = h;
      e.valid = v;
      exp_q.push_back(e);
    end
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_pending", exp_q.size(), 32'd0);
  endtask

  initial begin
    logic [7:0] partial;
    partial = 8'h5A;
    rx    = 1'b1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data",  {24'd0, data_out}, 32'h00);
    check("rst_hex",   {28'd0, hex_out},  32'h0);
    check("rst_valid", {31'd0, hex_valid}, 32'd0);
    check("rst_ready", {31'd0, ready_out}, 32'd0);
`ifdef UART_RX_HEX_FRAME_ERR_EN
    check("rst_ferr",  {31'd0, frame_err}, 32'd0);
`endif
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // '7'
    send_frame(8'h37, 1'b1, 1'b1, 4'd7, 1'b1);
    wait_drain();

    // 'A' then 'f' with no idle gap
    send_frame(8'h41, 1'b1, 1'b1, 4'd10, 1'b1);
    send_frame(8'h66, 1'b1, 1'b1, 4'd15, 1'b1);
    wait_drain();
    check("strobes_after_af", strobes, 32'd3);

    // 'G' is not a hex digit
    send_frame(8'h47, 1'b1, 1'b1, 4'd0, 1'b0);
    wait_drain();

    // 3-clock glitch is rejected as a false start
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (30) @(negedge clk);
    check("strobes_after_glitch", strobes, 32'd4);
    check("glitch_hold_data", {24'd0, data_out}, 32'h47);

    send_frame(8'h35, 1'b1, 1'b1, 4'd5, 1'b1);
    wait_drain();

    // '9' with a bad stop bit: dropped, outputs hold
    send_frame(8'h39, 1'b0, 1'b0, 4'd0, 1'b0);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("ferr_no_strobe", strobes, 32'd5);
    check("ferr_hold_data",  {24'd0, data_out}, 32'h35);
    check("ferr_hold_hex",   {28'd0, hex_out},  32'h5);
    check("ferr_hold_valid", {31'd0, hex_valid}, 32'd1);
`ifdef UART_RX_HEX_FRAME_ERR_EN
    check("ferr_pulses", ferr_seen, 32'd1);
`endif

    // Reset in the middle of data bit 4
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(partial[i]);
    rx = partial[4];
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("midrst_data",  {24'd0, data_out}, 32'h00);
    check("midrst_hex",   {28'd0, hex_out},  32'h0);
    check("midrst_valid", {31'd0, hex_valid}, 32'd0);
    check("midrst_ready", {31'd0, ready_out}, 32'd0);
    repeat (3) @(negedge clk);
    rx    = 1'b1;
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("midrst_no_strobe", strobes, 32'd5);

    // 'c' after recovery
    send_frame(8'h63, 1'b1, 1'b1, 4'd12, 1'b1);
    wait_drain();
    check("final_strobes", strobes, 32'd6);
`ifdef UART_RX_HEX_FRAME_ERR_EN
    check("final_ferr", ferr_seen, 32'd1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
